// File: rtl/tug_referee_if.sv
// Referee-side bundle for the tug-of-war playfield.
// master: field/player side. It drives L, R, leftEnd and rightEnd, and it sees the referee results.
// slave : referee side. It sees the presses and end lights, and it drives newGame, scores, roundWinner and matchOver.
interface tug_referee_if #(
  parameter int unsigned SCORE_W = 3
);
  logic               L;
  logic               R;
  logic               leftEnd;
  logic               rightEnd;
  logic               newGame;
  logic [SCORE_W-1:0] leftScore;
  logic [SCORE_W-1:0] rightScore;
  logic [1:0]         roundWinner;
  logic               matchOver;

  modport master (
    output L, R, leftEnd, rightEnd,
    input  newGame, leftScore, rightScore, roundWinner, matchOver
  );

  modport slave (
    input  L, R, leftEnd, rightEnd,
    output newGame, leftScore, rightScore, roundWinner, matchOver
  );
endinterface

// File: rtl/tug_referee.sv
// Match referee at the far end of the field light chain.
// The referee watches the two outermost field lights and the player press pulses.
// It declares a round winner and keeps a score for each player.
// After PAUSE_CYCLES it pulses newGame to re-centre the field.
// The match ends when a score reaches MAX_SCORE.
// Ports:
//   clk   - system clock
//   Reset - synchronous, active-high reset
//   bus   - tug_referee_if.slave carrying the following signals:
//           inputs  L, R, leftEnd, rightEnd
//           outputs newGame, leftScore, rightScore, roundWinner, matchOver
//           All outputs are registered.
module tug_referee #(
  parameter int unsigned MAX_SCORE    = 7,
  parameter int unsigned SCORE_W      = 3,
  parameter int unsigned PAUSE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           Reset,
  tug_referee_if.slave   bus
);

  localparam int unsigned          CNT_W      = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX  = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    PAUSE   = 2'd1,
    NEWGAME = 2'd2,
    OVER    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               new_game_q, new_game_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic [1:0]         winner_q, winner_d;
  logic               match_over_q, match_over_d;

  logic               left_win, right_win;
  logic [SCORE_W-1:0] left_next, right_next;

  // Round decode. Both end lights lit is an illegal field, so it blocks any win.
  // L&R together fails both terms, so a simultaneous press never wins.
  always_comb begin
    left_win   = 1'b0;
    right_win  = 1'b0;
    left_next  = left_score_q + SCORE_W'(1);
    right_next = right_score_q + SCORE_W'(1);
    if (state_q == PLAY && !(bus.leftEnd && bus.rightEnd)) begin
      left_win  = bus.leftEnd  &&  bus.L && !bus.R;
      right_win = bus.rightEnd &&  bus.R && !bus.L;
    end
  end

  // State register and all output/datapath flops
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= PLAY;
      cnt_q         <= '0;
      new_game_q    <= 1'b0;
      left_score_q  <= '0;
      right_score_q <= '0;
      winner_q      <= 2'b00;
      match_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      new_game_q    <= new_game_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      winner_q      <= winner_d;
      match_over_q  <= match_over_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PLAY: begin
        if (left_win)
          state_d = (left_next == SCORE_MAX) ? OVER : PAUSE;
        else if (right_win)
          state_d = (right_next == SCORE_MAX) ? OVER : PAUSE;
      end
      PAUSE:   if (cnt_q == PAUSE_LAST) state_d = NEWGAME;
      NEWGAME: state_d = PLAY;
      OVER:    state_d = OVER;
      default: state_d = PLAY;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_d         = cnt_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    winner_d      = winner_q;
    match_over_d  = match_over_q;
    // newGame is registered, so it is high for exactly the one cycle spent in NEWGAME.
    new_game_d    = (state_d == NEWGAME);
    unique case (state_q)
      PLAY: begin
        if (left_win) begin
          left_score_d = left_next;
          winner_d     = 2'b10;
          match_over_d = (left_next == SCORE_MAX);
          cnt_d        = '0;
        end else if (right_win) begin
          right_score_d = right_next;
          winner_d      = 2'b01;
          match_over_d  = (right_next == SCORE_MAX);
          cnt_d         = '0;
        end
      end
      PAUSE:   cnt_d = cnt_q + CNT_W'(1);
      NEWGAME: winner_d = 2'b00;
      default: ;
    endcase
  end

  assign bus.newGame     = new_game_q;
  assign bus.leftScore   = left_score_q;
  assign bus.rightScore  = right_score_q;
  assign bus.roundWinner = winner_q;
  assign bus.matchOver   = match_over_q;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee. The DUT uses MAX_SCORE=3 and PAUSE_CYCLES=4.
module tb_tug_referee;

  logic clk = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ng_count = 0;

  always #5 clk = ~clk;

  tug_referee_if #(.SCORE_W(3)) bus ();

  tug_referee #(
    .MAX_SCORE   (3),
    .SCORE_W     (3),
    .PAUSE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always @(negedge clk) if (bus.newGame === 1'b1) ng_count++;

  typedef struct {
    logic       l, r, le, re;
    logic       ng;
    logic [2:0] ls, rs;
    logic [1:0] rw;
    logic       mo;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic l, logic r, logic le, logic re, logic ng,
                              logic [2:0] ls, logic [2:0] rs, logic [1:0] rw, logic mo);
    vec_t v;
    v.l = l; v.r = r; v.le = le; v.re = re;
    v.ng = ng; v.ls = ls; v.rs = rs; v.rw = rw; v.mo = mo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic r, input logic le, input logic re);
    bus.L = l; bus.R = r; bus.leftEnd = le; bus.rightEnd = re;
  endtask

  task automatic chk_all(input string tag, input logic ng, input logic [2:0] ls,
                         input logic [2:0] rs, input logic [1:0] rw, input logic mo);
    chk({tag, " newGame"},     32'(bus.newGame),     32'(ng));
    chk({tag, " leftScore"},   32'(bus.leftScore),   32'(ls));
    chk({tag, " rightScore"},  32'(bus.rightScore),  32'(rs));
    chk({tag, " roundWinner"}, 32'(bus.roundWinner), 32'(rw));
    chk({tag, " matchOver"},   32'(bus.matchOver),   32'(mo));
  endtask

  initial begin
    int base;

    // Table scenario starts from PLAY with both scores 0. Each row is applied for one edge.
    vecs[0]  = mk(0,0,0,0, 0, 0,0, 2'b00, 0);
    vecs[1]  = mk(1,1,0,1, 0, 0,0, 2'b00, 0); // L&R with rightEnd lit: no win
    vecs[2]  = mk(0,1,1,1, 0, 0,0, 2'b00, 0); // illegal field blocks R
    vecs[3]  = mk(1,0,1,1, 0, 0,0, 2'b00, 0); // illegal field blocks L
    vecs[4]  = mk(1,0,0,0, 0, 0,0, 2'b00, 0); // no end light lit
    vecs[5]  = mk(1,0,1,0, 0, 1,0, 2'b10, 0); // edge k: left wins
    vecs[6]  = mk(1,1,1,1, 0, 1,0, 2'b10, 0); // PAUSE: presses ignored
    vecs[7]  = mk(0,1,1,1, 0, 1,0, 2'b10, 0);
    vecs[8]  = mk(1,0,1,1, 0, 1,0, 2'b10, 0);
    vecs[9]  = mk(0,0,0,0, 1, 1,0, 2'b10, 0); // after edge k+4: newGame
    vecs[10] = mk(1,0,1,0, 0, 1,0, 2'b00, 0); // NEWGAME ignores L; winner cleared
    vecs[11] = mk(0,1,0,1, 0, 1,1, 2'b01, 0); // right wins
    vecs[12] = mk(0,0,0,0, 0, 1,1, 2'b01, 0);
    vecs[13] = mk(0,0,0,0, 0, 1,1, 2'b01, 0);
    vecs[14] = mk(0,0,0,0, 0, 1,1, 2'b01, 0);
    vecs[15] = mk(0,0,0,0, 1, 1,1, 2'b01, 0);
    vecs[16] = mk(0,0,0,0, 0, 1,1, 2'b00, 0);
    vecs[17] = mk(1,1,1,0, 0, 1,1, 2'b00, 0); // L&R with leftEnd lit: no win

    // Reset held 3 cycles, then 5 idle cycles
    drive(0,0,0,0);
    Reset = 1'b1;
    repeat (3) step();
    chk_all("reset", 0, 0, 0, 2'b00, 0);
    Reset = 1'b0;
    base = ng_count;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 2'b00, 0);
    end
    chk("idle newGame count", 32'(ng_count - base), 32'd0);

    // Table-driven round play
    base = ng_count;
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].l, vecs[i].r, vecs[i].le, vecs[i].re);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ng, vecs[i].ls, vecs[i].rs, vecs[i].rw, vecs[i].mo);
    end
    drive(0,0,0,0);
    chk("table newGame count", 32'(ng_count - base), 32'd2);

    // Match end: three right wins with MAX_SCORE=3
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    base = ng_count;
    for (int w = 0; w < 3; w++) begin
      drive(0,1,0,1);
      step();
      drive(0,0,0,0);
      chk_all($sformatf("maxwin%0d", w), 0, 0, 3'(w + 1), 2'b01, (w == 2));
      if (w < 2) begin
        repeat (5) step();
        chk($sformatf("maxwin%0d cleared", w), 32'(bus.roundWinner), 32'd0);
      end
    end
    chk("max newGame count", 32'(ng_count - base), 32'd2);
    for (int i = 0; i < 12; i++) begin
      drive(i[0], i[1], i[2], i[3] | i[0]);
      step();
      chk_all($sformatf("over%0d", i), 0, 0, 3, 2'b01, 1);
    end
    drive(0,0,0,0);
    chk("over newGame count", 32'(ng_count - base), 32'd2);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk_all("over reset", 0, 0, 0, 2'b00, 0);

    // Reset on edge k+2 after a left win aborts the pending newGame
    base = ng_count;
    drive(1,0,1,0);
    step();
    drive(0,0,0,0);
    chk_all("abort win", 0, 1, 0, 2'b10, 0);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk_all("abort reset", 0, 0, 0, 2'b00, 0);
    repeat (8) step();
    chk("abort newGame count", 32'(ng_count - base), 32'd0);
    chk("abort leftScore", 32'(bus.leftScore), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
